bram_fifo_ctrl: RTL and testbench

Stream-to-BRAM front end for the single-port block RAM: converts a valid/ready push stream and a valid/ready pop stream into single-port RAM commands, forming a first-word-fall-through FIFO with the RAM as storage. Sits directly upstream of the single-port BRAM. It drives the RAM's write enable, read enable, address and write data, and consumes the RAM's registered read data through a 2-entry output buffer. Because the RAM port can do only one access per cycle, this block arbitrates between writes and read fetches.

---
 rtl/bram_fifo_ctrl.sv | 136 +++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl
//   Stream-to-BRAM front end. Turns a valid/ready push stream and a
//   valid/ready pop stream into commands for one single-port block RAM,
//   giving a first-word-fall-through FIFO that uses the RAM as storage.
//   The RAM port does one access per cycle, so writes (pushes) and read
//   fetches share it. Fetched words come back one cycle later through the
//   RAM's output register and land in a 2-entry output buffer (ob). The
//   head of ob drives m_data.
//
//   Build option:
//     BRAM_FIFO_CTRL_WRPRIO_EN  undefined: fetch priority. s_ready is low
//                                whenever a fetch is wanted.
//                               defined  : write priority. An accepted push
//                                blocks that cycle's fetch.
//
//   Ports:
//     clk, rst          clock; asynchronous active-high reset
//     s_valid/s_ready/s_data   push stream
//     m_valid/m_ready/m_data   pop stream (m_data = oldest word)
//     count             words held: RAM + in-flight + output buffer
//     full              RAM region holds DEPTH words
//     empty             count == 0
//     ram_wr_en, ram_rd_en, ram_addr, ram_din   RAM command port
//     ram_dout          RAM registered read data, valid 1 cycle after rd_en
module bram_fifo_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  ram_wr_en,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0]       wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]         ram_cnt;
    logic                        inflight;
    logic [1:0]                  ob_cnt, ob_cnt_nxt;
    logic [1:0][DATA_WIDTH-1:0]  ob_q, ob_nxt;

    logic fetch_cond, fetch, push, pop, cap;
    logic ob_slot;

    // Fetch only when the output buffer has room for everything already in
    // flight plus the new word. Registers only, so the timing stays short.
    assign fetch_cond = (ram_cnt != '0) &&
                        (({1'b0, ob_cnt} + {2'b00, inflight}) < 3'd2);

    assign full = (ram_cnt == DEPTH_C);

`ifdef BRAM_FIFO_CTRL_WRPRIO_EN
    // The push wins the port. A fetch waits for a cycle with no accepted push.
    assign s_ready = !full;
    assign fetch   = fetch_cond && !(s_valid && !full);
`else
    // The fetch wins the port. The push side is stalled while a fetch is due.
    assign s_ready = !full && !fetch_cond;
    assign fetch   = fetch_cond;
`endif

    assign push = s_valid && s_ready;
    assign pop  = m_valid && m_ready;
    assign cap  = inflight;

    // RAM command port. push and fetch exclude each other, so the two
    // enables are never high together.
    assign ram_wr_en = push;
    assign ram_rd_en = fetch;
    assign ram_addr  = fetch ? rd_ptr : wr_ptr;
    assign ram_din   = s_data;

    assign m_valid = (ob_cnt != 2'd0);
    assign m_data  = ob_q[0];

    assign count = ram_cnt
                 + {{ADDR_WIDTH{1'b0}}, inflight}
                 + {{(ADDR_WIDTH-1){1'b0}}, ob_cnt};
    assign empty = (count == '0);

    // Output buffer next state. Entry 0 is the head. A pop shifts entry 1
    // down. A capture writes the first free slot after that shift. ob never
    // overflows, because fetch_cond counts the in-flight word.
    always_comb begin
        ob_nxt     = ob_q;
        ob_cnt_nxt = ob_cnt;
        ob_slot    = 1'b0;
        if (pop) begin
            ob_nxt[0]  = ob_q[1];
            ob_cnt_nxt = ob_cnt - 2'd1;
        end
        if (cap) begin
            ob_slot         = ob_cnt_nxt[0];
            ob_nxt[ob_slot] = ram_dout;
            ob_cnt_nxt      = ob_cnt_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            ob_cnt   <= 2'd0;
            ob_q     <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (fetch)
                rd_ptr <= rd_ptr + 1'b1;
            if (push)
                ram_cnt <= ram_cnt + 1'b1;
            else if (fetch)
                ram_cnt <= ram_cnt - 1'b1;
            // Each fetch's data is captured on the following edge.
            inflight <= fetch;
            ob_cnt   <= ob_cnt_nxt;
            ob_q     <= ob_nxt;
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
module tb_bram_fifo_ctrl;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data;
    logic [AW:0]   count;
    logic          full, empty;
    logic          ram_wr_en, ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    bram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .full(full), .empty(empty),
        .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Single-port BRAM with a registered read port.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_din;
        if (ram_rd_en) ram_dout <= mem[ram_addr];
    end

    int            n_chk  = 0;
    int            n_pass = 0;
    logic [DW-1:0] q[$];   // reference: every word the block holds, oldest first
    logic          acc, popd;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    // One clock cycle. Called at a negedge and returns at the next negedge.
    task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr,
                        output logic hp, output logic hpop);
        s_valid = sv; s_data = sd; m_ready = mr;
        #1;
        hp   = s_valid && s_ready;
        hpop = m_valid && m_ready;
        chk("one_port", {31'd0, ram_wr_en && ram_rd_en}, 0);
        chk("wr_while_full", {31'd0, ram_wr_en && full}, 0);
`ifdef BRAM_FIFO_CTRL_WRPRIO_EN
        if (hp) chk("wp_fetch_on_push", {31'd0, ram_rd_en}, 0);
`endif
        if (hp) chk("no_overflow", {31'd0, q.size() < DEPTH + 2}, 1);
        if (hpop) begin
            chk("pop_nonempty", {31'd0, q.size() > 0}, 1);
            if (q.size() > 0) chk("pop_data", {16'd0, m_data}, {16'd0, q[0]});
        end
        @(posedge clk);
        if (hpop && q.size() > 0) void'(q.pop_front());
        if (hp) q.push_back(sd);
        @(negedge clk);
        chk("count", {27'd0, count}, q.size());
        chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
    endtask

    task automatic drain_all(input string tag);
        int n = 0;
        while (q.size() > 0 && n < 8 * DEPTH + 20) begin
            step(1'b0, '0, 1'b1, acc, popd);
            n++;
        end
        chk(tag, q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, cyc, npop;
        logic saw_low;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 1);
        chk("rst_m_valid", {31'd0, m_valid}, 0);
        chk("rst_m_data",  {16'd0, m_data}, 0);
        chk("rst_count",   {27'd0, count}, 0);
        chk("rst_full",    {31'd0, full}, 0);
        chk("rst_empty",   {31'd0, empty}, 1);
        chk("rst_wr_en",   {31'd0, ram_wr_en}, 0);
        chk("rst_rd_en",   {31'd0, ram_rd_en}, 0);
        chk("rst_addr",    {28'd0, ram_addr}, 0);
        rst = 1'b0;

        // Idle for 20 cycles.
        for (int k = 0; k < 20; k++) begin
            step(1'b0, '0, 1'b0, acc, popd);
            chk("idle_s_ready", {31'd0, s_ready}, 1);
            chk("idle_en", {30'd0, ram_wr_en, ram_rd_en}, 0);
        end

        // A single word appears 3 cycles after its push.
        step(1'b1, 16'h1234, 1'b0, acc, popd);
        chk("lat_acc", {31'd0, acc}, 1);
        chk("lat_c1", {31'd0, m_valid}, 0);
        step(1'b0, '0, 1'b0, acc, popd);
        chk("lat_c2", {31'd0, m_valid}, 0);
        step(1'b0, '0, 1'b0, acc, popd);
        chk("lat_c3", {31'd0, m_valid}, 1);
        chk("lat_data", {16'd0, m_data}, 32'h1234);
        step(1'b0, '0, 1'b1, acc, popd);
        chk("lat_pop", {31'd0, popd}, 1);

        // Reset in the middle of a stream discards everything.
        for (int k = 0; k < 5; k++) step(1'b1, DW'(k + 100), 1'b0, acc, popd);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_count", {27'd0, count}, 0);
        chk("midrst_m_valid", {31'd0, m_valid}, 0);
        rst = 1'b0;
        q.delete();

        // Fill to DEPTH+2 with the pop side stalled. Addresses wrap past DEPTH-1.
        i = 0; cyc = 0;
        while (i < DEPTH + 2 && cyc < 8 * DEPTH) begin
            step(1'b1, DW'(i), 1'b0, acc, popd);
            if (acc) i++;
            cyc++;
        end
        chk("fill_words", i, DEPTH + 2);
        chk("fill_full", {31'd0, full}, 1);
        chk("fill_s_ready", {31'd0, s_ready}, 0);
        chk("fill_count", {27'd0, count}, DEPTH + 2);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 16'hDEAD, 1'b0, acc, popd);
            chk("full_reject", {31'd0, acc}, 0);
        end

        // Drain. Order is enforced by the pop_data checks against q.
        npop = 0; cyc = 0;
        while (q.size() > 0 && cyc < 8 * DEPTH) begin
            step(1'b0, '0, 1'b1, acc, popd);
            if (popd) npop++;
            cyc++;
        end
        chk("drain_words", npop, DEPTH + 2);
        chk("drain_empty", {31'd0, empty}, 1);

        // Random traffic.
        for (int k = 0; k < 10000; k++)
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), acc, popd);
        drain_all("rand_drain");

        // Data present, push held high: the output buffer runs dry and
        // m_valid falls.
        rst = 1'b1; @(negedge clk); rst = 1'b0; q.delete();
        i = 0; cyc = 0;
        while (i < 4 && cyc < 40) begin
            step(1'b1, DW'(16'h0A00 + i), 1'b0, acc, popd);
            if (acc) i++;
            cyc++;
        end
        for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0, acc, popd);
        saw_low = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, DW'(16'h0B00 + k), 1'b1, acc, popd);
`ifdef BRAM_FIFO_CTRL_WRPRIO_EN
            chk("wp_push_acc", {31'd0, acc}, 1);
`endif
            if (!m_valid) saw_low = 1'b1;
        end
        chk("hold_mv_falls", {31'd0, saw_low}, 1);
        drain_all("hold_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
